// File: rtl/clink_pkg.sv
// Shared types and fixed-point helpers for the Clink cell update path.
// CLINK_CELL_SAT_EN selects saturating (vs wrapping) reductions.
package clink_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 1;

    localparam logic signed [DATA_W-1:0] FX_ONE = DATA_W'(1 << FRAC_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_I    = 3'd1,
        S_G    = 3'd2,
        S_F    = 3'd3,
        S_O    = 3'd4
    } cell_state_t;

`ifdef CLINK_CELL_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SUM_W'(1 << (DATA_W - 1));
`endif

    function automatic logic [DATA_W-1:0] fx_reduce(
        input logic signed [SUM_W-1:0] v
    );
`ifdef CLINK_CELL_SAT_EN
        if (v > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] htanh(
        input logic signed [DATA_W-1:0] v
    );
        if (v > FX_ONE)
            return FX_ONE;
        else if (v < -FX_ONE)
            return -FX_ONE;
        else
            return v;
    endfunction

endpackage

// File: rtl/clink_fx_mul.sv
// Signed Q-format multiply with floor shift; NARROW=1 also reduces the
// result to DATA_W (saturating when CLINK_CELL_SAT_EN is defined).
module clink_fx_mul
    import clink_pkg::*;
#(
    parameter bit NARROW = 1'b0,
    parameter int OUT_W  = NARROW ? DATA_W : PROD_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  y
);

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    assign prod    = $signed(a) * $signed(b);
    assign shifted = prod >>> FRAC_W;

    generate
        if (NARROW) begin : g_narrow
            assign y = fx_reduce({shifted[PROD_W-1], shifted});
        end else begin : g_wide
            assign y = shifted;
        end
    endgenerate

endmodule

// File: rtl/clink_cell_update.sv
// LSTM cell update: collects I,G,F,O gates, updates c and emits h per step.
// CLINK_CELL_SAT_EN selects saturating reductions of c and h.
module clink_cell_update
    import clink_pkg::*;
#(
    parameter int NUM_STEPS = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seq_start,
    input  logic              gate_valid,
    input  logic [DATA_W-1:0] gate_data,
    output logic              h_valid,
    output logic [DATA_W-1:0] h_data,
    output logic [DATA_W-1:0] c_data,
    output logic [2:0]        step_idx,
    output logic              seq_done,
    output logic              busy
);

    cell_state_t state, state_nx;

    logic [DATA_W-1:0] c_reg;
    logic [DATA_W-1:0] i_reg;
    logic [DATA_W-1:0] g_reg;

    logic acc_i, acc_g, acc_f, acc_o;
    logic last_step;

    logic [PROD_W-1:0] fc_w;
    logic [PROD_W-1:0] ig_w;
    logic [DATA_W-1:0] oh_n;
    logic [SUM_W-1:0]  c_sum;

    clink_fx_mul #(.NARROW(1'b0)) u_mul_fc (
        .a (gate_data),
        .b (c_reg),
        .y (fc_w)
    );

    clink_fx_mul #(.NARROW(1'b0)) u_mul_ig (
        .a (i_reg),
        .b (g_reg),
        .y (ig_w)
    );

    clink_fx_mul #(.NARROW(1'b1)) u_mul_oh (
        .a (gate_data),
        .b (htanh(c_reg)),
        .y (oh_n)
    );

    assign c_sum = {fc_w[PROD_W-1], fc_w} + {ig_w[PROD_W-1], ig_w};

    assign last_step = (step_idx == 3'(NUM_STEPS - 1));
    assign c_data    = c_reg;

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (seq_start) begin
            state_nx = S_I;
        end else if (gate_valid) begin
            unique case (state)
                S_I:     state_nx = S_G;
                S_G:     state_nx = S_F;
                S_F:     state_nx = S_O;
                S_O:     state_nx = last_step ? S_IDLE : S_I;
                default: state_nx = state;
            endcase
        end
    end

    // seq_start always wins, so a gate arriving with it is dropped
    always_comb begin
        busy  = (state != S_IDLE);
        acc_i = gate_valid && !seq_start && (state == S_I);
        acc_g = gate_valid && !seq_start && (state == S_G);
        acc_f = gate_valid && !seq_start && (state == S_F);
        acc_o = gate_valid && !seq_start && (state == S_O);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_reg    <= '0;
            i_reg    <= '0;
            g_reg    <= '0;
            h_data   <= '0;
            step_idx <= '0;
            h_valid  <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            h_valid  <= 1'b0;
            seq_done <= 1'b0;
            if (seq_start) begin
                c_reg    <= '0;
                step_idx <= '0;
            end
            if (acc_i)
                i_reg <= gate_data;
            if (acc_g)
                g_reg <= gate_data;
            if (acc_f)
                c_reg <= fx_reduce(c_sum);
            if (acc_o) begin
                h_data  <= oh_n;
                h_valid <= 1'b1;
                if (last_step) begin
                    seq_done <= 1'b1;
                    step_idx <= '0;
                end else begin
                    step_idx <= step_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clink_cell_update.sv
// Scoreboard bench for clink_cell_update: driver queues expected h/c,
// a negedge monitor checks each h_valid pulse against the queue.
module tb_clink_cell_update;

    logic        clock;
    logic        reset;
    logic        seq_start;
    logic        gate_valid;
    logic [15:0] gate_data;
    logic        h_valid;
    logic [15:0] h_data;
    logic [15:0] c_data;
    logic [2:0]  step_idx;
    logic        seq_done;
    logic        busy;

    typedef struct {
        logic signed [15:0] h;
        logic signed [15:0] c;
        logic               done;
        int                 cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    clink_cell_update #(.NUM_STEPS(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .seq_start  (seq_start),
        .gate_valid (gate_valid),
        .gate_data  (gate_data),
        .h_valid    (h_valid),
        .h_data     (h_data),
        .c_data     (c_data),
        .step_idx   (step_idx),
        .seq_done   (seq_done),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic signed [31:0] act,
                       input logic signed [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && h_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_h_valid", 32'sd1, 32'sd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("h_data", $signed(h_data), e.h);
                chk("c_data", $signed(c_data), e.c);
                chk("seq_done", {31'd0, seq_done}, {31'd0, e.done});
                chk("h_latency", cyc, e.cyc);
            end
        end else if (!reset && seq_done) begin
            chk("seq_done_without_h", 32'sd1, 32'sd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic gate(input logic [15:0] v);
        gate_valid = 1'b1;
        gate_data  = v;
        tick();
        gate_valid = 1'b0;
    endtask

    task automatic start();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic run_step(input logic signed [15:0] i, g, f, o,
                            input logic signed [15:0] eh, ec,
                            input logic done);
        exp_t e;
        gate(i);
        gate(g);
        gate(f);
        e.h    = eh;
        e.c    = ec;
        e.done = done;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        gate(o);
    endtask

    initial begin
        reset      = 1'b1;
        seq_start  = 1'b0;
        gate_valid = 1'b0;
        gate_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_h_valid", {31'd0, h_valid}, 0);
        chk("rst_h_data", $signed(h_data), 0);
        chk("rst_c_data", $signed(c_data), 0);
        chk("rst_step_idx", {29'd0, step_idx}, 0);

        // gate in idle is ignored
        gate(16'sd4096);
        gate(16'sd4096);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_step_idx", {29'd0, step_idx}, 0);

        // converging sequence: c += half of the remaining gap to 1.0
        start();
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_step_idx", {29'd0, step_idx}, 0);
        run_step(2048, 4096, 2048, 4096, 2048, 2048, 1'b0);
        chk("step_idx_1", {29'd0, step_idx}, 1);
        run_step(2048, 4096, 2048, 4096, 3072, 3072, 1'b0);
        chk("step_idx_2", {29'd0, step_idx}, 2);
        run_step(2048, 4096, 2048, 4096, 3584, 3584, 1'b0);
        run_step(2048, 4096, 2048, 4096, 3840, 3840, 1'b0);
        run_step(2048, 4096, 2048, 4096, 3968, 3968, 1'b1);
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_step_idx", {29'd0, step_idx}, 0);
        tick();
        chk("post_done_h_valid", {31'd0, h_valid}, 0);

        // negative clamp, floor rounding, overflow reduction
        start();
        run_step(-4096, 8192, 0, 2048, -2048, -8192, 1'b0);
        run_step(-1, 1, 0, 4096, -1, -1, 1'b0);
`ifdef CLINK_CELL_SAT_EN
        run_step(28672, 28672, 0, 4096, 4096, 32767, 1'b0);
        run_step(4096, 1024, 4096, 4096, 4096, 32767, 1'b0);
        run_step(0, 0, -4096, -4096, 4096, -32767, 1'b1);
`else
        run_step(28672, 28672, 0, 4096, 4096, 4096, 1'b0);
        run_step(4096, 1024, 4096, 4096, 4096, 5120, 1'b0);
        run_step(0, 0, -4096, -4096, 4096, -5120, 1'b1);
`endif

        // abort in S_F with a coincident gate
        start();
        run_step(2048, 4096, 2048, 4096, 2048, 2048, 1'b0);
        gate(2048);
        gate(4096);
        seq_start  = 1'b1;
        gate_valid = 1'b1;
        gate_data  = 16'sd2048;
        tick();
        seq_start  = 1'b0;
        gate_valid = 1'b0;
        chk("abort_c_data", $signed(c_data), 0);
        chk("abort_step_idx", {29'd0, step_idx}, 0);
        chk("abort_busy", {31'd0, busy}, 1);
        chk("abort_h_valid", {31'd0, h_valid}, 0);
        run_step(2048, 4096, 2048, 4096, 2048, 2048, 1'b0);

        // reset mid-sequence
        gate(2048);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_c_data", $signed(c_data), 0);
        chk("mid_rst_h_data", $signed(h_data), 0);
        chk("mid_rst_step_idx", {29'd0, step_idx}, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            tick();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses missing, expected 0",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
